// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic family (subtractor now,
// adder/comparator later): control-state encoding and default operand width.
package serial_subtractor_pkg;

  localparam int unsigned SUB_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle between a register-side requester and a serial
// arithmetic unit: start/a/b in, busy/done/diff/borrow_out back.
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
  );

endinterface

// File: rtl/serial_subtractor_half_subtractor.sv
// Combinational half subtractor: d = x - y (mod 2), bo = borrow out.
// Dual of the half-adder cell; two of these form one full-subtractor stage.
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);

  assign d  = x ^ y;
  assign bo = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock.
// Produces diff = a - b mod 2^WIDTH and the final borrow (a < b unsigned).
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  sub_state_e       state_q;
  sub_state_e       state_d;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_nxt;
  logic [CNT_W-1:0] cnt;
  logic             borrow;
  logic             borrow_nxt;
  logic             load;
  logic             last_bit;

  logic             d1;
  logic             b1;
  logic             d;
  logic             b2;

  // Full-subtractor stage: (x - y) first, then subtract the incoming borrow.
  half_subtractor u_hs1 (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .d  (d1),
    .bo (b1)
  );

  half_subtractor u_hs2 (
    .x  (d1),
    .y  (borrow),
    .d  (d),
    .bo (b2)
  );

  assign borrow_nxt = b1 | b2;
  assign res_nxt    = {d, res_sh[WIDTH-1:1]};
  assign last_bit   = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (last_bit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh           <= '0;
      b_sh           <= '0;
      res_sh         <= '0;
      cnt            <= '0;
      borrow         <= 1'b0;
      bus.diff       <= '0;
      bus.borrow_out <= 1'b0;
    end else if (load) begin
      a_sh   <= bus.a;
      b_sh   <= bus.b;
      cnt    <= '0;
      borrow <= 1'b0;
    end else if (state_q == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_nxt;
      cnt    <= cnt + 1'b1;
      borrow <= borrow_nxt;
      // Result is published from the shift value including the final bit,
      // so diff/borrow_out move only on the DONE-entry edge.
      if (last_bit) begin
        bus.diff       <= res_nxt;
        bus.borrow_out <= borrow_nxt;
      end
    end
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor that computes diff = a - b, LSB first, one bit per clock, and flags the final borrow.
- It is the inverse arithmetic companion to the team's half-adder cell and is built from two half-subtractor cells, used as a full subtractor.
- It sits between a register-side requester (start/done handshake) and any datapath that prefers low area over single-cycle subtraction.

Parameters:
- WIDTH, 8, operand and result width in bits (minimum 2).
- CNT_W, $clog2(WIDTH), width of the internal bit counter (derived; not overridden).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request pulse; sampled only when busy=0.
- a  input  WIDTH  minuend; captured on the accepted start edge.
- b  input  WIDTH  subtrahend; captured on the accepted start edge.
- busy  output  1  high while the serial operation is in progress.
- done  output  1  one-cycle pulse when diff/borrow_out are valid.
- diff  output  WIDTH  result a - b modulo 2^WIDTH; holds until the next completion.
- borrow_out  output  1  1 when a < b (unsigned); holds with diff.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; busy=0, done=0, diff=0, borrow_out=0.
  - Operand shift registers, result shift register, bit counter and borrow flop all cleared.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 -> load a_sh=a, b_sh=b, borrow=0, cnt=0; go to RUN.
  - RUN: each edge processes bit cnt:
    - x=a_sh[0], y=b_sh[0], bin=borrow.
    - Half-sub 1 on (x, y): d1=x^y, b1=~x&y.
    - Half-sub 2 on (d1, bin): d=d1^bin, b2=~d1&bin.
    - Next borrow = b1|b2.
    - d shifts into the MSB of res_sh (res_sh shifts right); a_sh and b_sh shift right; cnt increments.
  - RUN exit: when cnt==WIDTH-1 on that edge, go to DONE. On the same edge register diff = final res_sh (including this bit), borrow_out = final borrow, done=1.
  - DONE: lasts exactly one cycle; done=1. Next edge: done=0. If start=1 it is accepted (back-to-back) and the block enters RUN with new operands; else it goes to IDLE.
- busy = (state==RUN), driven combinationally from the state register.
- Latency: start accepted at edge T0. Bits are processed at edges T0+1 .. T0+WIDTH. done is high in the cycle after edge T0+WIDTH. busy is high for exactly WIDTH cycles.
- Throughput: one result per WIDTH+1 cycles with back-to-back starts.
- Boundaries:
  - start while busy=1: ignored, with no effect on the operation in progress.
  - a/b changes after acceptance: no effect (operands are captured).
  - a==b gives diff=0, borrow_out=0.
  - a=0, b=2^WIDTH-1 gives diff=1, borrow_out=1.
  - diff wraps modulo 2^WIDTH.
  - rst_n asserted mid-RUN: immediate abort to IDLE, all outputs 0, no done pulse. The first start after release behaves normally.
  - diff/borrow_out change only on the DONE-entry edge or on reset.

Decomposition:
- Shared package: state enum (IDLE/RUN/DONE, 2-bit encoding) and the WIDTH default constant, so the future serial adder/comparator share them.
- One natural sub-module: half_subtractor, combinational (inputs x, y; outputs d=x^y, bo=~x&y). Instantiated twice to form the full-subtractor stage; it is the exact dual of the team's half adder.

Test Plan:
- WIDTH=8, a=0x35, b=0x12, start pulse -> busy high 8 cycles, done pulse one cycle later, diff=0x23, borrow_out=0.
- a=0x12, b=0x35 -> diff=0xDD, borrow_out=1. a=0x00, b=0x01 -> diff=0xFF, borrow_out=1.
- a=0xFF, b=0xFF -> diff=0x00, borrow_out=0. Then an immediate start in the DONE cycle with a=0x80, b=0x01 -> diff=0x7F, done exactly 9 cycles after the first done.
- Start a=0x50, b=0x20, then pulse start with a=0x00, b=0xFF at cycle 3 of RUN -> second start ignored, result diff=0x30, borrow_out=0.
- Start a=0x10, b=0x20, drop rst_n at cycle 4 of RUN -> busy, done, diff, borrow_out all 0 immediately, and no done pulse afterwards. After release, a=0x09, b=0x04 -> diff=0x05.
- Exhaustive random check (all 65536 a/b pairs, or 10k random pairs) against reference a-b: diff and borrow_out match, done count equals start-accept count.
